// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the mips_16 core: captures decoded operands, drives the ALU
// inputs and flags load-use hazards. Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
   parameter int unsigned DW  = 16,
   parameter int unsigned RAW = 3,
   parameter int unsigned CW  = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           stall,
   input  logic           flush,
   input  logic           id_valid,
   input  logic [RAW-1:0] id_rs1,
   input  logic [RAW-1:0] id_rs2,
   input  logic [DW-1:0]  id_rs1_data,
   input  logic [DW-1:0]  id_rs2_data,
   input  logic [DW-1:0]  id_imm,
   input  logic           id_use_imm,
   input  logic [CW-1:0]  id_cmd,
   input  logic           id_mem_read,
   input  logic           id_wb_en,
   input  logic [RAW-1:0] id_wb_dest,
   input  logic           exmem_wb_en,
   input  logic [RAW-1:0] exmem_dest,
   input  logic [DW-1:0]  exmem_result,
   input  logic           memwb_wb_en,
   input  logic [RAW-1:0] memwb_dest,
   input  logic [DW-1:0]  memwb_result,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [CW-1:0]  alu_cmd,
   output logic           ex_valid,
   output logic           ex_mem_read,
   output logic           ex_wb_en,
   output logic [RAW-1:0] ex_wb_dest,
   output logic [DW-1:0]  ex_rs2_fwd,
   output logic           load_use_stall
);

   localparam logic [CW-1:0] ALU_NC = CW'(0);

   logic           r_valid;
   logic [RAW-1:0] r_rs1;
   logic [RAW-1:0] r_rs2;
   logic [DW-1:0]  r_rs1_data;
   logic [DW-1:0]  r_rs2_data;
   logic [DW-1:0]  r_imm;
   logic           r_use_imm;
   logic [CW-1:0]  r_cmd;
   logic           r_mem_read;
   logic           r_wb_en;
   logic [RAW-1:0] r_wb_dest;

   logic [DW-1:0]  w_rs1_fwd;
   logic [DW-1:0]  w_rs2_fwd;

   // Stage register: flush beats stall; an invalid decode slot is captured as a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_use_imm  <= 1'b0;
         r_cmd      <= ALU_NC;
         r_mem_read <= 1'b0;
         r_wb_en    <= 1'b0;
         r_wb_dest  <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_cmd      <= ALU_NC;
         r_mem_read <= 1'b0;
         r_wb_en    <= 1'b0;
      end else if (!stall) begin
         r_valid    <= id_valid;
         r_rs1      <= id_rs1;
         r_rs2      <= id_rs2;
         r_rs1_data <= id_rs1_data;
         r_rs2_data <= id_rs2_data;
         r_imm      <= id_imm;
         r_use_imm  <= id_use_imm;
         r_cmd      <= id_valid ? id_cmd : ALU_NC;
         r_mem_read <= id_valid & id_mem_read;
         r_wb_en    <= id_valid & id_wb_en;
         r_wb_dest  <= id_wb_dest;
      end
   end

`ifdef ID_EX_FORWARD_EN
   logic w_rs1_hit_ex;
   logic w_rs1_hit_wb;
   logic w_rs2_hit_ex;
   logic w_rs2_hit_wb;

   // R0 never forwards; the younger EX/MEM result wins over MEM/WB.
   assign w_rs1_hit_ex = exmem_wb_en && (exmem_dest == r_rs1) && (r_rs1 != '0);
   assign w_rs1_hit_wb = memwb_wb_en && (memwb_dest == r_rs1) && (r_rs1 != '0);
   assign w_rs2_hit_ex = exmem_wb_en && (exmem_dest == r_rs2) && (r_rs2 != '0);
   assign w_rs2_hit_wb = memwb_wb_en && (memwb_dest == r_rs2) && (r_rs2 != '0);

   assign w_rs1_fwd = w_rs1_hit_ex ? exmem_result :
                      w_rs1_hit_wb ? memwb_result : r_rs1_data;
   assign w_rs2_fwd = w_rs2_hit_ex ? exmem_result :
                      w_rs2_hit_wb ? memwb_result : r_rs2_data;
`else
   logic w_unused;

   // Without forwarding the hazard unit resolves every RAW dependency by stalling.
   assign w_rs1_fwd = r_rs1_data;
   assign w_rs2_fwd = r_rs2_data;
   assign w_unused  = ^{exmem_wb_en, exmem_dest, exmem_result,
                        memwb_wb_en, memwb_dest, memwb_result, r_rs1, r_rs2};
`endif

   assign alu_a       = w_rs1_fwd;
   assign alu_b       = r_use_imm ? r_imm : w_rs2_fwd;
   assign ex_rs2_fwd  = w_rs2_fwd;
   assign alu_cmd     = r_cmd;
   assign ex_valid    = r_valid;
   assign ex_mem_read = r_mem_read;
   assign ex_wb_en    = r_wb_en;
   assign ex_wb_dest  = r_wb_dest;

   // A load in EX cannot feed the instruction in ID without one bubble.
   assign load_use_stall = id_valid && r_valid && r_mem_read && (r_wb_dest != '0) &&
                           ((id_rs1 == r_wb_dest) || (!id_use_imm && (id_rs2 == r_wb_dest)));

endmodule
